slb_mem_responder: RTL and testbench
====================================

// Module: slb_mem_responder
// PURPOSE
//   Memory-side responder for the SLB byte-serial access protocol, plus an instruction-fetch port.
//   Grants one SLB byte per cycle onto the single-port byte RAM and returns read data one cycle later.
//   Serves 4-byte instruction fetches when the SLB is idle or has used up its burst allowance.
//   Sits between the SLB/fetch unit and the RAM/IO bus.
// PARAMETERS
//   ADDR_WIDTH     17  RAM address width; ram_a = addr[ADDR_WIDTH-1:0], so addresses wrap mod 2^ADDR_WIDTH.
//   MAX_SLB_BURST  8   Max consecutive SLB grants while if_req is pending before the fetch port wins.
// PORTS
//   clk_in              in   1   clock
//   rst_in              in   1   asynchronous, active-low reset
//   rdy_in              in   1   global ready; low = freeze
//   control_hazard      in   1   ROB flush; aborts the in-flight fetch
//   slb_access_control  in   1   SLB requests a byte access at slb_mem_addr
//   slb_mem_addr        in   32  byte address
//   slb_mem_wr          in   1   1 = write slb_mem_dout
//   slb_mem_dout        in   8   store byte
//   slb_access_valid    out  1   byte granted this cycle (combinational)
//   slb_mem_din         out  8   read byte; valid the cycle after the grant
//   if_req              in   1   fetch request; held until if_valid or control_hazard
//   if_addr             in   32  fetch address
//   if_valid            out  1   one-cycle pulse: if_data valid
//   if_data             out  32  fetched word, little-endian
//   ram_din             in   8   RAM read data; 1-cycle latency
//   ram_dout            out  8   RAM write data
//   ram_a               out  ADDR_WIDTH  RAM address
//   ram_wr              out  1   RAM write enable
//   io_buffer_full      in   1   IO write FIFO is full
// BEHAVIOUR
//   Reset (rst_in=0, async): state=IDLE, byte_cnt=0, burst_cnt=0; all outputs 0.
//   States:
//     IDLE: each cycle, arbitrate:
//       - SLB granted if slb_access_control && !(if_req && burst_cnt==MAX_SLB_BURST).
//       - Otherwise, if if_req: go to IF_RD with byte_cnt=0; byte 0 is issued in this same cycle.
//     IF_RD: issue byte byte_cnt at if_addr+byte_cnt, one byte per cycle; byte 3 -> IF_DONE.
//       - The fetch is atomic: the SLB is not granted in IF_RD.
//     IF_DONE: capture byte 3; next cycle if_valid=1 and state returns to IDLE.
//   SLB grant cycle t:
//     - slb_access_valid=1.
//     - ram_a=slb_mem_addr, ram_wr=slb_mem_wr, ram_dout=slb_mem_dout.
//     - slb_mem_din=ram_din during t+1 (direct pass-through).
//   Grant rules:
//     - No grant in a cycle with control_hazard=1 or rdy_in=0.
//     - No grant while rst_in=0.
//   burst_cnt:
//     - +1 per SLB grant while if_req=1, saturating at MAX_SLB_BURST.
//     - Cleared when a fetch starts or when if_req=0.
//   Fetch timing:
//     - Request accepted in cycle t0; bytes issued t0..t0+3.
//     - Byte k is latched into if_data[8k+7:8k] at the end of cycle t0+k+1.
//     - if_valid=1 in cycle t0+5 only.
//     - if_data holds its value until the next fetch completes.
//   Address arithmetic: the if_addr+byte_cnt carry is dropped above ADDR_WIDTH (wrap-around).
//   control_hazard in IF_RD/IF_DONE: state=IDLE next cycle, no if_valid, in-flight bytes discarded.
//   rdy_in=0: state, counters and if_data frozen; ram_wr=0; the fetch resumes from the same byte_cnt.
//   Simultaneous SLB and IF requests in IDLE with burst_cnt<MAX_SLB_BURST: SLB wins.
//   Reset asserted mid-fetch: immediate IDLE, no if_valid.
// CONFIGURATION
//   MEM_IO_STALL_EN defined:
//     - SLB write grants are blocked while io_buffer_full=1 and slb_mem_addr[17:16]==2'b11.
//     - Reads and fetches are unaffected.
//   MEM_IO_STALL_EN undefined: io_buffer_full is ignored.
// TESTING
//   SLB byte read: addr 0x100, RAM[0x100]=0xA5.
//     -> slb_access_valid=1 and ram_a=0x100 in cycle t; slb_mem_din=0xA5 in t+1.
//   SLB 4-byte store of 0x11223344 to 0x200.
//     -> 4 consecutive grants; RAM[0x200..0x203]=44,33,22,11.
//   Fetch at 0x1000 with RAM bytes 13,05,00,00.
//     -> if_valid at t0+5, if_data=0x00000513.
//   if_req and a continuous SLB stream, MAX_SLB_BURST=8.
//     -> exactly 8 SLB grants, then the fetch starts; no SLB grant during the 4 fetch cycles.
//   control_hazard at t0+2 of a fetch.
//     -> no if_valid; IDLE at t0+3; a new if_req is served normally.
//   MEM_IO_STALL_EN, write to 0x30000 with io_buffer_full=1 for 3 cycles.
//     -> no grant and ram_wr=0 for those cycles; grant on the cycle full drops.

Source files
------------

// File: rtl/slb_mem_responder_if.sv
// SLB / instruction-fetch / RAM signal bundle for slb_mem_responder.
// The slave modport is the responder's view; the master modport is the SLB, fetch unit and RAM side.
interface slb_mem_responder_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  slb_access_control;
  logic [31:0]           slb_mem_addr;
  logic                  slb_mem_wr;
  logic [7:0]            slb_mem_dout;
  logic                  slb_access_valid;
  logic [7:0]            slb_mem_din;
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_valid;
  logic [31:0]           if_data;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;
  logic                  io_buffer_full;

  modport slave (
    input  slb_access_control, slb_mem_addr, slb_mem_wr, slb_mem_dout,
    input  if_req, if_addr, ram_din, io_buffer_full,
    output slb_access_valid, slb_mem_din, if_valid, if_data,
    output ram_dout, ram_a, ram_wr
  );

  modport master (
    output slb_access_control, slb_mem_addr, slb_mem_wr, slb_mem_dout,
    output if_req, if_addr, ram_din, io_buffer_full,
    input  slb_access_valid, slb_mem_din, if_valid, if_data,
    input  ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/slb_mem_responder.sv
// Arbitrates SLB byte accesses and 4-byte instruction fetches onto a single-port byte RAM.
// Optional MEM_IO_STALL_EN: hold off SLB writes to the IO window (addr[17:16]==2'b11) while the IO FIFO is full.
module slb_mem_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int MAX_SLB_BURST = 8
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  input logic             control_hazard,
  slb_mem_responder_if.slave bus
);

  localparam int BURST_W = $clog2(MAX_SLB_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    IF_RD,
    IF_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [23:0]          fetch_buf_q, fetch_buf_d;
  logic [31:0]          if_data_q, if_data_d;
  logic                 if_valid_q, if_valid_d;
  logic                 slb_grant_q;

  logic                 burst_full;
  logic                 io_block;
  logic                 arb_ok;
  logic                 slb_grant;
  logic                 fetch_start;
  logic [1:0]           latch_idx;
  logic [1:0]           issue_off;
  logic [ADDR_WIDTH-1:0] fetch_base;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                 unused_bits;

`ifdef MEM_IO_STALL_EN
  assign io_block = bus.io_buffer_full && bus.slb_mem_wr && (bus.slb_mem_addr[17:16] == 2'b11);
`else
  assign io_block = 1'b0;
`endif

  assign unused_bits = ^{bus.slb_mem_addr[31:ADDR_WIDTH], bus.if_addr[31:ADDR_WIDTH], bus.io_buffer_full};

  assign burst_full  = (burst_cnt_q == BURST_W'(MAX_SLB_BURST));
  assign arb_ok      = rst_in && rdy_in && !control_hazard && (state_q == IDLE);
  assign slb_grant   = arb_ok && bus.slb_access_control && !(bus.if_req && burst_full) && !io_block;
  assign fetch_start = arb_ok && !slb_grant && bus.if_req;

  // byte_cnt is the next byte to issue; the byte returning from RAM this cycle is byte_cnt-1.
  // While frozen, the RAM is pointed back at that returning byte so ram_din is still valid on resume.
  assign latch_idx  = byte_cnt_q - 2'd1;
  assign issue_off  = (rdy_in && state_q == IF_RD) ? byte_cnt_q : latch_idx;
  assign fetch_base = bus.if_addr[ADDR_WIDTH-1:0];
  assign fetch_addr = fetch_base + {{(ADDR_WIDTH-2){1'b0}}, issue_off};

  assign bus.slb_access_valid = slb_grant;
  assign bus.ram_wr           = slb_grant && bus.slb_mem_wr;
  assign bus.ram_dout         = slb_grant ? bus.slb_mem_dout : 8'h00;
  assign bus.ram_a            = slb_grant   ? bus.slb_mem_addr[ADDR_WIDTH-1:0] :
                                fetch_start ? fetch_base :
                                (state_q != IDLE) ? fetch_addr : '0;
  assign bus.slb_mem_din      = slb_grant_q ? bus.ram_din : 8'h00;
  assign bus.if_valid         = if_valid_q;
  assign bus.if_data          = if_data_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    burst_cnt_d = burst_cnt_q;
    fetch_buf_d = fetch_buf_q;
    if_data_d   = if_data_q;
    if_valid_d  = 1'b0;

    if (control_hazard && state_q != IDLE) begin
      state_d    = IDLE;
      byte_cnt_d = 2'd0;
    end else if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (fetch_start) begin
            state_d    = IF_RD;
            byte_cnt_d = 2'd1;
          end
        end
        IF_RD: begin
          case (latch_idx)
            2'd0:    fetch_buf_d[7:0]   = bus.ram_din;
            2'd1:    fetch_buf_d[15:8]  = bus.ram_din;
            2'd2:    fetch_buf_d[23:16] = bus.ram_din;
            default: fetch_buf_d        = fetch_buf_q;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = IF_DONE;
          end
        end
        IF_DONE: begin
          if_data_d  = {bus.ram_din, fetch_buf_q};
          if_valid_d = 1'b1;
          byte_cnt_d = 2'd0;
          state_d    = IDLE;
        end
        default: begin
          state_d    = IDLE;
          byte_cnt_d = 2'd0;
        end
      endcase
    end

    if (rdy_in) begin
      if (!bus.if_req || fetch_start) begin
        burst_cnt_d = '0;
      end else if (slb_grant && !burst_full) begin
        burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 2'd0;
      burst_cnt_q <= '0;
      fetch_buf_q <= 24'h0;
      if_data_q   <= 32'h0;
      if_valid_q  <= 1'b0;
      slb_grant_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      fetch_buf_q <= fetch_buf_d;
      if_data_q   <= if_data_d;
      if_valid_q  <= if_valid_d;
      slb_grant_q <= slb_grant;
    end
  end

endmodule

// File: tb/tb_slb_mem_responder.sv
// Self-checking bench for slb_mem_responder: single-cycle SLB vectors from a table, then
// hand-written fetch, burst-limit, hazard, freeze, reset and IO-stall sequences.
module tb_slb_mem_responder;
  localparam int AW = 17;

  typedef struct {
    logic        ctrl;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  dout;
    logic        if_req;
    logic        rdy;
    logic        hazard;
    logic        exp_valid;
    logic [16:0] exp_a;
    logic        exp_wr;
    logic [7:0]  exp_dout;
    logic [7:0]  exp_din;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in;
  logic control_hazard;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd_byte;
  vec_t vecs [0:10];

  slb_mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

  slb_mem_responder #(.ADDR_WIDTH(AW), .MAX_SLB_BURST(8)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .control_hazard(control_hazard),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  // Byte RAM with one-cycle read latency; read-before-write on the same address.
  always @(posedge clk_in) begin
    rd_byte = mem[bus.ram_a];
    if (bus.ram_wr) mem[bus.ram_a] = bus.ram_dout;
    bus.ram_din <= rd_byte;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    bus.slb_access_control = 1'b0;
    bus.slb_mem_addr       = 32'h0;
    bus.slb_mem_wr         = 1'b0;
    bus.slb_mem_dout       = 8'h00;
    bus.if_req             = 1'b0;
    bus.if_addr            = 32'h0;
    bus.io_buffer_full     = 1'b0;
    rdy_in                 = 1'b1;
    control_hazard         = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.slb_access_control = v.ctrl;
    bus.slb_mem_addr       = v.addr;
    bus.slb_mem_wr         = v.wr;
    bus.slb_mem_dout       = v.dout;
    bus.if_req             = v.if_req;
    bus.if_addr            = 32'h1000;
    rdy_in                 = v.rdy;
    control_hazard         = v.hazard;
  endtask

  task automatic checkOutput(input vec_t v, input int i);
    check($sformatf("vec%0d_valid", i), {31'h0, bus.slb_access_valid}, {31'h0, v.exp_valid});
    check($sformatf("vec%0d_ram_a", i), {15'h0, bus.ram_a}, {15'h0, v.exp_a});
    check($sformatf("vec%0d_ram_wr", i), {31'h0, bus.ram_wr}, {31'h0, v.exp_wr});
    check($sformatf("vec%0d_ram_dout", i), {24'h0, bus.ram_dout}, {24'h0, v.exp_dout});
  endtask

  task automatic slbRead(input logic [31:0] addr, input logic [7:0] exp, input string name);
    @(negedge clk_in);
    bus.slb_access_control = 1'b1;
    bus.slb_mem_wr = 1'b0;
    bus.slb_mem_addr = addr;
    #1;
    check({name, "_grant"}, {31'h0, bus.slb_access_valid}, 32'h1);
    @(negedge clk_in);
    bus.slb_access_control = 1'b0;
    check({name, "_din"}, {24'h0, bus.slb_mem_din}, {24'h0, exp});
  endtask

  // Starts a fetch at the current negedge (cycle t0) and watches cycles t0+1..t0+8.
  task automatic runFetch(input logic [31:0] addr, input logic [31:0] exp, input string name);
    int vcyc = -1;
    int pulses = 0;
    logic [16:0] a2;
    a2 = 17'(addr + 32'd2);
    bus.if_req = 1'b1;
    bus.if_addr = addr;
    #1;
    check({name, "_a0"}, {15'h0, bus.ram_a}, {15'h0, addr[16:0]});
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk_in);
      if (n == 2) check({name, "_a2"}, {15'h0, bus.ram_a}, {15'h0, a2});
      if (bus.if_valid) begin
        pulses++;
        if (vcyc < 0) begin
          vcyc = n;
          check({name, "_data"}, bus.if_data, exp);
        end
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    check({name, "_valid_cycle"}, vcyc, 5);
    check({name, "_pulses"}, pulses, 1);
  endtask

  initial begin
    int grants_pre, first_nogrant, vcyc, pulses;
    bit grant13;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[17'h00100] = 8'hA5;
    mem[17'h00101] = 8'h5A;
    mem[17'h01000] = 8'h13;
    mem[17'h01001] = 8'h05;
    mem[17'h1FFFE] = 8'h55;
    mem[17'h1FFFF] = 8'h66;
    mem[17'h00000] = 8'h77;
    mem[17'h00001] = 8'h88;

    //            ctrl  addr          wr    dout   ifreq rdy   hz    valid a            wr    dout   din
    vecs[0]  = '{1'b1, 32'h00000100, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00100, 1'b0, 8'h00, 8'hA5};
    vecs[1]  = '{1'b1, 32'h00000101, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00101, 1'b0, 8'h00, 8'h5A};
    vecs[2]  = '{1'b1, 32'h00020100, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00100, 1'b0, 8'h00, 8'hA5};
    vecs[3]  = '{1'b1, 32'h00000100, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00000, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 32'h00000101, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{1'b1, 32'h00000300, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00300, 1'b1, 8'hC3, 8'h00};
    vecs[6]  = '{1'b1, 32'h00000300, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00300, 1'b0, 8'h00, 8'hC3};
    vecs[7]  = '{1'b0, 32'h00000300, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 17'h00000, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 32'h00000100, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 17'h00100, 1'b0, 8'h00, 8'hA5};
    vecs[9]  = '{1'b1, 32'h00000101, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00101, 1'b0, 8'h00, 8'h5A};
    vecs[10] = '{1'b1, 32'h00000100, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00100, 1'b0, 8'h00, 8'hA5};

    idleInputs();
    bus.slb_access_control = 1'b1;
    bus.slb_mem_addr = 32'h100;
    bus.if_req = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_valid", {31'h0, bus.slb_access_valid}, 32'h0);
    check("rst_ram_a", {15'h0, bus.ram_a}, 32'h0);
    check("rst_ram_wr", {31'h0, bus.ram_wr}, 32'h0);
    check("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
    check("rst_if_data", bus.if_data, 32'h0);
    check("rst_din", {24'h0, bus.slb_mem_din}, 32'h0);
    idleInputs();
    rst_in = 1'b1;

    $display("[TB] table vectors");
    @(negedge clk_in);
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
      @(negedge clk_in);
      check($sformatf("vec%0d_din", i), {24'h0, bus.slb_mem_din}, {24'h0, vecs[i].exp_din});
    end
    idleInputs();

    $display("[TB] 4-byte SLB store");
    @(negedge clk_in);
    bus.slb_mem_wr = 1'b1;
    bus.slb_access_control = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.slb_mem_addr = 32'h200 + k;
      bus.slb_mem_dout = 8'(32'h11223344 >> (8 * k));
      #1;
      check($sformatf("store%0d_grant", k), {31'h0, bus.slb_access_valid}, 32'h1);
      @(negedge clk_in);
    end
    idleInputs();
    slbRead(32'h200, 8'h44, "st_rd0");
    slbRead(32'h201, 8'h33, "st_rd1");
    slbRead(32'h202, 8'h22, "st_rd2");
    slbRead(32'h203, 8'h11, "st_rd3");

    $display("[TB] fetches");
    @(negedge clk_in);
    runFetch(32'h1000, 32'h00000513, "fetch1000");
    @(negedge clk_in);
    runFetch(32'h1FFFE, 32'h88776655, "fetch_wrap");

    $display("[TB] burst limit");
    @(negedge clk_in);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    bus.slb_access_control = 1'b1;
    bus.slb_mem_addr = 32'h100;
    grants_pre = 0; first_nogrant = -1; vcyc = -1; grant13 = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (n > 0) @(negedge clk_in);
      if (bus.if_valid && vcyc < 0) begin
        vcyc = n;
        bus.if_req = 1'b0;
      end
      #1;
      if (n < 13 && bus.slb_access_valid) grants_pre++;
      if (first_nogrant < 0 && !bus.slb_access_valid) first_nogrant = n;
      if (n == 13) grant13 = bus.slb_access_valid;
    end
    idleInputs();
    check("burst_grants", grants_pre, 8);
    check("burst_first_block", first_nogrant, 8);
    check("burst_if_valid_cycle", vcyc, 13);
    check("burst_if_data", bus.if_data, 32'h00000513);
    check("burst_grant_after", {31'h0, grant13}, 32'h1);

    $display("[TB] control hazard");
    @(negedge clk_in);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1FFFE;
    pulses = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk_in);
      if (bus.if_valid) pulses++;
      if (n == 2) begin
        control_hazard = 1'b1;
        bus.if_req = 1'b0;
      end
      if (n == 3) begin
        control_hazard = 1'b0;
        bus.slb_access_control = 1'b1;
        bus.slb_mem_addr = 32'h100;
        #1;
        check("hz_idle_grant", {31'h0, bus.slb_access_valid}, 32'h1);
      end
      if (n == 4) bus.slb_access_control = 1'b0;
    end
    check("hz_no_valid", pulses, 0);
    check("hz_if_data_held", bus.if_data, 32'h00000513);
    @(negedge clk_in);
    runFetch(32'h1FFFE, 32'h88776655, "fetch_after_hz");

    $display("[TB] freeze mid-fetch");
    @(negedge clk_in);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1000;
    vcyc = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk_in);
      if (bus.if_valid && vcyc < 0) begin
        vcyc = n;
        check("stall_if_data", bus.if_data, 32'h00000513);
        bus.if_req = 1'b0;
      end
      if (n == 2) rdy_in = 1'b0;
      if (n == 4) rdy_in = 1'b1;
    end
    idleInputs();
    check("stall_valid_cycle", vcyc, 7);

    $display("[TB] reset mid-fetch");
    @(negedge clk_in);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h1FFFE;
    pulses = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk_in);
      if (bus.if_valid) pulses++;
      if (n == 2) begin
        rst_in = 1'b0;
        bus.if_req = 1'b0;
        #1;
        check("rstmid_if_data", bus.if_data, 32'h0);
        check("rstmid_ram_a", {15'h0, bus.ram_a}, 32'h0);
      end
      if (n == 3) rst_in = 1'b1;
    end
    check("rstmid_no_valid", pulses, 0);
    slbRead(32'h101, 8'h5A, "rstmid_rd");

    $display("[TB] IO buffer full write");
    @(negedge clk_in);
    bus.slb_access_control = 1'b1;
    bus.slb_mem_wr = 1'b1;
    bus.slb_mem_addr = 32'h30000;
    bus.slb_mem_dout = 8'h5C;
    bus.io_buffer_full = 1'b1;
`ifdef MEM_IO_STALL_EN
    for (int n = 0; n < 4; n++) begin
      if (n > 0) @(negedge clk_in);
      if (n == 3) bus.io_buffer_full = 1'b0;
      #1;
      check($sformatf("io%0d_grant", n), {31'h0, bus.slb_access_valid}, (n == 3) ? 32'h1 : 32'h0);
      check($sformatf("io%0d_ram_wr", n), {31'h0, bus.ram_wr}, (n == 3) ? 32'h1 : 32'h0);
    end
`else
    #1;
    check("io_grant", {31'h0, bus.slb_access_valid}, 32'h1);
    check("io_ram_wr", {31'h0, bus.ram_wr}, 32'h1);
`endif
    check("io_ram_a", {15'h0, bus.ram_a}, 32'h10000);
    @(negedge clk_in);
    idleInputs();
    slbRead(32'h30000, 8'h5C, "io_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
